// File: rtl/lock_pkg.sv
// Shared state encoding and per-state control outputs for the autolock sequencer.
package lock_pkg;
  localparam int STW = 3;

  typedef enum logic [STW-1:0] {
    ST_IDLE   = 3'd0,
    ST_SWEEP  = 3'd1,
    ST_ENGAGE = 3'd2,
    ST_SETTLE = 3'd3,
    ST_LOCKED = 3'd4,
    ST_LOST   = 3'd5
  } lock_state_e;

  typedef struct packed {
    logic int_rst;
    logic ifreeze;
    logic freeze;
    logic locked;
  } lock_ctl_t;

  // Control lines seen by the PID block while resident in a given state.
  function automatic lock_ctl_t ctl_of(lock_state_e s);
    case (s)
      ST_SWEEP:  ctl_of = '{int_rst: 1'b1, ifreeze: 1'b1, freeze: 1'b0, locked: 1'b0};
      ST_ENGAGE: ctl_of = '{int_rst: 1'b1, ifreeze: 1'b1, freeze: 1'b0, locked: 1'b0};
      ST_SETTLE: ctl_of = '{int_rst: 1'b0, ifreeze: 1'b0, freeze: 1'b0, locked: 1'b0};
      ST_LOCKED: ctl_of = '{int_rst: 1'b0, ifreeze: 1'b0, freeze: 1'b0, locked: 1'b1};
      ST_LOST:   ctl_of = '{int_rst: 1'b0, ifreeze: 1'b1, freeze: 1'b1, locked: 1'b0};
      default:   ctl_of = '{int_rst: 1'b1, ifreeze: 1'b1, freeze: 1'b0, locked: 1'b0};
    endcase
  endfunction
endpackage

// File: rtl/lock_sweep_gen.sv
// Triangle sweep generator: bounces between lo and hi by step per enabled clock.
module lock_sweep_gen #(
  parameter int DW = 14
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 load_i,
  input  logic                 en_i,
  input  logic signed [DW-1:0] load_val_i,
  input  logic signed [DW-1:0] lo_i,
  input  logic signed [DW-1:0] hi_i,
  input  logic        [DW-1:0] step_i,
  output logic signed [DW-1:0] sweep_o,
  output logic signed [DW-1:0] nxt_o
);
  logic                 dir, dir_n;  // 0 = up, 1 = down
  logic signed [DW+1:0] lo_x, hi_x, cur_x, step_x, sum_x;

  // Two guard bits so any offset/step combination compares exactly against the bounds.
  assign lo_x   = (DW+2)'(lo_i);
  assign hi_x   = (DW+2)'(hi_i);
  assign cur_x  = (DW+2)'(sweep_o);
  assign step_x = $signed({2'b00, step_i});
  assign sum_x  = dir ? cur_x - step_x : cur_x + step_x;

  always_comb begin
    nxt_o = sweep_o;
    dir_n = dir;
    if (load_i) begin
      nxt_o = load_val_i;
      dir_n = 1'b0;
    end else if (en_i) begin
      if (lo_i >= hi_i) begin
        nxt_o = lo_i;
      end else if (sum_x > hi_x) begin
        nxt_o = hi_i;
        dir_n = 1'b1;
      end else if (sum_x < lo_x) begin
        nxt_o = lo_i;
        dir_n = 1'b0;
      end else begin
        nxt_o = sum_x[DW-1:0];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sweep_o <= '0;
      dir     <= 1'b0;
    end else begin
      sweep_o <= nxt_o;
      dir     <= dir_n;
    end
  end
endmodule

// File: rtl/lock_pid_sequencer.sv
// Autolock sequencer: sweep, trigger on rising error crossing, engage, settle, supervise lock.
module lock_pid_sequencer
  import lock_pkg::*;
#(
  parameter int DW = 14,
  parameter int CW = 32
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 start_i,
  input  logic                 stop_i,
  input  logic                 relock_i,
  input  logic signed [DW-1:0] err_i,
  input  logic signed [DW-1:0] sweep_lo_i,
  input  logic signed [DW-1:0] sweep_hi_i,
  input  logic        [DW-1:0] sweep_step_i,
  input  logic signed [DW-1:0] trig_lvl_i,
  input  logic        [DW-1:0] win_i,
  input  logic        [CW-1:0] settle_i,
  input  logic        [CW-1:0] lost_i,
  output logic                 int_rst_o,
  output logic signed [DW-1:0] int_rst_val_o,
  output logic                 pid_ifreeze_o,
  output logic                 pid_freeze_o,
  output logic signed [DW-1:0] sweep_o,
  output logic                 locked_o,
  output logic [STW-1:0]       state_o
);
  lock_state_e          st;
  lock_ctl_t            ctl;
  logic signed [DW-1:0] anchor, prev_err, sweep_nxt, load_val;
  logic signed [DW:0]   err_x;
  logic        [DW:0]   err_abs;
  logic        [CW-1:0] cnt, lost_eff;
  logic                 prev_vld, in_win, trig, settle_done, lost_hit;
  logic                 relock_go, gen_load, gen_en;

  assign err_x       = (DW+1)'(err_i);
  assign err_abs     = err_x[DW] ? $unsigned(-err_x) : $unsigned(err_x);
  assign in_win      = err_abs <= {1'b0, win_i};
  assign trig        = prev_vld && (prev_err < trig_lvl_i) && (err_i >= trig_lvl_i);
  assign settle_done = cnt == settle_i;
  assign lost_eff    = (lost_i == '0) ? CW'(1) : lost_i;
  assign lost_hit    = !in_win && (cnt + CW'(1) >= lost_eff);

  // Re-entry into SWEEP after a failed settle or a lost lock resumes from the anchor.
  assign relock_go = relock_i && ((st == ST_LOST) || (st == ST_SETTLE && settle_done && !in_win));
  assign gen_load  = stop_i || start_i || (st == ST_IDLE) || relock_go;
  assign load_val  = (relock_go && !stop_i && !start_i) ? anchor : sweep_lo_i;
  assign gen_en    = (st == ST_SWEEP) && !trig && !stop_i && !start_i;

  lock_sweep_gen #(.DW(DW)) u_sweep (
    .clk_i      (clk_i),
    .rst_i      (rstn_i),
    .load_i     (gen_load),
    .en_i       (gen_en),
    .load_val_i (load_val),
    .lo_i       (sweep_lo_i),
    .hi_i       (sweep_hi_i),
    .step_i     (sweep_step_i),
    .sweep_o    (sweep_o),
    .nxt_o      (sweep_nxt)
  );

  always_ff @(posedge clk_i) begin
    if (rstn_i) begin
      st            <= ST_IDLE;
      ctl           <= ctl_of(ST_IDLE);
      cnt           <= '0;
      anchor        <= '0;
      prev_err      <= '0;
      prev_vld      <= 1'b0;
      int_rst_val_o <= '0;
    end else begin
      prev_err      <= err_i;
      prev_vld      <= gen_en;
      int_rst_val_o <= sweep_nxt;
      cnt           <= '0;
      if (stop_i) begin
        st <= ST_IDLE;   ctl <= ctl_of(ST_IDLE);
      end else if (start_i) begin
        st <= ST_SWEEP;  ctl <= ctl_of(ST_SWEEP);
      end else begin
        case (st)
          ST_IDLE: ;
          ST_SWEEP:
            if (trig) begin
              anchor <= sweep_o;
              st <= ST_ENGAGE; ctl <= ctl_of(ST_ENGAGE);
            end
          ST_ENGAGE: begin
            st <= ST_SETTLE; ctl <= ctl_of(ST_SETTLE);
          end
          ST_SETTLE:
            if (!settle_done)  cnt <= cnt + CW'(1);
            else if (in_win) begin
              st <= ST_LOCKED; ctl <= ctl_of(ST_LOCKED);
            end else if (relock_i) begin
              st <= ST_SWEEP;  ctl <= ctl_of(ST_SWEEP);
            end else begin
              st <= ST_LOST;   ctl <= ctl_of(ST_LOST);
            end
          ST_LOCKED:
            if (lost_hit) begin
              st <= ST_LOST;   ctl <= ctl_of(ST_LOST);
            end else if (!in_win) cnt <= cnt + CW'(1);
          ST_LOST:
            if (relock_i) begin
              st <= ST_SWEEP;  ctl <= ctl_of(ST_SWEEP);
            end
          default: begin
            st <= ST_IDLE;   ctl <= ctl_of(ST_IDLE);
          end
        endcase
      end
    end
  end

  assign int_rst_o     = ctl.int_rst;
  assign pid_ifreeze_o = ctl.ifreeze;
  assign pid_freeze_o  = ctl.freeze;
  assign locked_o      = ctl.locked;
  assign state_o       = st;
endmodule

// File: tb/tb_lock_pid_sequencer.sv
// Bench for lock_pid_sequencer: directed scenarios then random traffic against an integer model.
module tb_lock_pid_sequencer;
  localparam int DW = 14;
  localparam int CW = 32;
  localparam int IDLE = 0, SWEEP = 1, ENGAGE = 2, SETTLE = 3, LOCKED = 4, LOST = 5;

  logic                 clk_i = 1'b0;
  logic                 rstn_i, start_i, stop_i, relock_i;
  logic signed [DW-1:0] err_i, sweep_lo_i, sweep_hi_i, trig_lvl_i;
  logic        [DW-1:0] sweep_step_i, win_i;
  logic        [CW-1:0] settle_i, lost_i;
  logic                 int_rst_o, pid_ifreeze_o, pid_freeze_o, locked_o;
  logic signed [DW-1:0] int_rst_val_o, sweep_o;
  logic [2:0]           state_o;

  lock_pid_sequencer #(.DW(DW), .CW(CW)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .start_i(start_i), .stop_i(stop_i), .relock_i(relock_i),
    .err_i(err_i), .sweep_lo_i(sweep_lo_i), .sweep_hi_i(sweep_hi_i), .sweep_step_i(sweep_step_i),
    .trig_lvl_i(trig_lvl_i), .win_i(win_i), .settle_i(settle_i), .lost_i(lost_i),
    .int_rst_o(int_rst_o), .int_rst_val_o(int_rst_val_o), .pid_ifreeze_o(pid_ifreeze_o),
    .pid_freeze_o(pid_freeze_o), .sweep_o(sweep_o), .locked_o(locked_o), .state_o(state_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0, n_err = 0;
  int m_st = 0, m_sw = 0, m_dir = 0, m_anchor = 0, m_prev = 0, m_pv = 0, m_cnt = 0;
  bit m_rst = 1'b0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model: one call per clock, using the inputs the DUT is about to sample.
  task automatic model_step();
    int lo  = sweep_lo_i;
    int hi  = sweep_hi_i;
    int stp = sweep_step_i;
    int e   = err_i;
    int tr  = trig_lvl_i;
    int w   = win_i;
    int lmax, ae, nx;
    bit inw, stay;
    m_rst = rstn_i;
    if (rstn_i) begin
      m_st = IDLE; m_sw = 0; m_dir = 0; m_anchor = 0; m_prev = 0; m_pv = 0; m_cnt = 0;
      return;
    end
    ae   = (e < 0) ? -e : e;
    inw  = ae <= w;
    lmax = (lost_i == 0) ? 1 : int'(lost_i);
    stay = 1'b0;
    if (stop_i) begin
      m_st = IDLE; m_sw = lo; m_dir = 0; m_cnt = 0;
    end else if (start_i) begin
      m_st = SWEEP; m_sw = lo; m_dir = 0; m_cnt = 0;
    end else begin
      case (m_st)
        IDLE: m_sw = lo;
        SWEEP:
          if (m_pv != 0 && m_prev < tr && e >= tr) begin
            m_anchor = m_sw; m_st = ENGAGE;
          end else begin
            stay = 1'b1;
            if (lo >= hi) m_sw = lo;
            else begin
              nx = (m_dir != 0) ? m_sw - stp : m_sw + stp;
              if (nx > hi)      begin m_sw = hi; m_dir = 1; end
              else if (nx < lo) begin m_sw = lo; m_dir = 0; end
              else m_sw = nx;
            end
          end
        ENGAGE: begin m_st = SETTLE; m_cnt = 0; end
        SETTLE:
          if (m_cnt != int'(settle_i)) m_cnt++;
          else begin
            m_cnt = 0;
            if (inw) m_st = LOCKED;
            else if (relock_i) begin m_st = SWEEP; m_sw = m_anchor; m_dir = 0; end
            else m_st = LOST;
          end
        LOCKED:
          if (inw) m_cnt = 0;
          else if (m_cnt + 1 >= lmax) begin m_st = LOST; m_cnt = 0; end
          else m_cnt++;
        LOST:
          if (relock_i) begin m_st = SWEEP; m_sw = m_anchor; m_dir = 0; end
        default: m_st = IDLE;
      endcase
    end
    m_pv   = stay ? 1 : 0;
    m_prev = e;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk_i);
    #1;
    chk("state", int'(state_o), m_st);
    chk("sweep", int'(sweep_o), m_sw);
    chk("locked", int'(locked_o), (m_st == LOCKED) ? 1 : 0);
    if (m_st != LOCKED) chk("int_rst", int'(int_rst_o), (m_st <= ENGAGE) ? 1 : 0);
    if (m_st != SWEEP && m_st != LOCKED) chk("ifreeze", int'(pid_ifreeze_o), (m_st == SETTLE) ? 0 : 1);
    if (m_st == IDLE || m_st == SETTLE || m_st == LOST) chk("freeze", int'(pid_freeze_o), (m_st == LOST) ? 1 : 0);
    if (m_rst) chk("irv_rst", int'(int_rst_val_o), 0);
    else if (m_st == SWEEP) chk("irv_sweep", int'(int_rst_val_o), m_sw);
    else if (m_st == ENGAGE) chk("irv_engage", int'(int_rst_val_o), m_anchor);
  endtask

  initial begin
    int r;
    rstn_i = 1'b1; start_i = 1'b0; stop_i = 1'b0; relock_i = 1'b0;
    err_i = '0; sweep_lo_i = '0; sweep_hi_i = '0; sweep_step_i = '0; trig_lvl_i = '0;
    win_i = '0; settle_i = '0; lost_i = '0;
    tick(); tick();
    chk("reset_state", int'(state_o), IDLE);
    chk("reset_irst", int'(int_rst_o), 1);
    rstn_i = 1'b0;

    // Triangle sweep with the error parked far below the trigger.
    sweep_lo_i = DW'(-100); sweep_hi_i = DW'(100); sweep_step_i = DW'(10);
    trig_lvl_i = '0; win_i = DW'(20); settle_i = 4; lost_i = 3; err_i = DW'(-500);
    tick();
    start_i = 1'b1; tick(); start_i = 1'b0;
    chk("s1_first", int'(sweep_o), -100);
    tick();
    chk("s1_second", int'(sweep_o), -90);
    repeat (45) tick();

    // Rising crossing at sweep_o == 30 on the upward leg.
    for (int i = 0; i < 80 && m_st != ENGAGE; i++) begin
      err_i = (m_st == SWEEP && m_dir == 0 && m_sw == 30) ? DW'(5) : DW'(-5);
      tick();
    end
    chk("s2_engage", int'(state_o), ENGAGE);
    chk("s2_anchor", int'(int_rst_val_o), 30);
    err_i = DW'(3);
    tick();
    chk("s2_settle_irst", int'(int_rst_o), 0);

    repeat (4) tick();
    chk("s3_still_settle", int'(state_o), SETTLE);
    tick();
    chk("s3_locked", int'(locked_o), 1);

    err_i = DW'(50); tick(); tick();
    err_i = '0; tick();
    err_i = DW'(50); tick(); tick();
    chk("s4_hold", int'(state_o), LOCKED);
    tick();
    chk("s4_lost", int'(state_o), LOST);
    chk("s4_freeze", int'(pid_freeze_o), 1);

    relock_i = 1'b1; tick();
    chk("s5_resweep", int'(state_o), SWEEP);
    chk("s5_anchor", int'(sweep_o), 30);
    repeat (3) tick();
    stop_i = 1'b1; start_i = 1'b1; tick();
    stop_i = 1'b0; start_i = 1'b0; relock_i = 1'b0;
    chk("s5_stop_wins", int'(state_o), IDLE);

    // Degenerate range, out-of-range |err|, reset mid-SETTLE.
    sweep_lo_i = DW'(7); sweep_hi_i = DW'(7); err_i = DW'(-5);
    start_i = 1'b1; tick(); start_i = 1'b0;
    repeat (5) tick();
    chk("s6_const", int'(sweep_o), 7);
    err_i = DW'(5); tick();
    chk("s6_engage", int'(state_o), ENGAGE);
    win_i = DW'(8191); settle_i = 2; err_i = DW'(-8192);
    repeat (4) tick();
    chk("s6_abs_out", int'(state_o), LOST);
    err_i = DW'(-5); start_i = 1'b1; tick(); start_i = 1'b0;
    tick();
    err_i = DW'(5); tick(); tick(); tick();
    chk("s6_in_settle", int'(state_o), SETTLE);
    rstn_i = 1'b1; tick(); rstn_i = 1'b0;
    chk("s6_rst_state", int'(state_o), IDLE);
    chk("s6_rst_sweep", int'(sweep_o), 0);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      if (c % 250 == 0) begin
        sweep_lo_i   = DW'(int'($urandom_range(120)) - 60);
        sweep_hi_i   = DW'(int'($urandom_range(120)) - 60);
        sweep_step_i = DW'($urandom_range(25));
        trig_lvl_i   = DW'(int'($urandom_range(20)) - 10);
        win_i        = DW'($urandom_range(30));
        settle_i     = CW'($urandom_range(5));
        lost_i       = CW'($urandom_range(4));
      end
      start_i = ($urandom_range(99) == 0);
      stop_i  = ($urandom_range(299) == 0);
      rstn_i  = ($urandom_range(499) == 0);
      if ($urandom_range(49) == 0) relock_i = ~relock_i;
      r = int'($urandom_range(99));
      err_i = (r < 3) ? DW'(-8192) : (r < 6) ? DW'(8191) : DW'(int'($urandom_range(80)) - 40);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
